fifomult_param: RTL and testbench

- Parametrised successor of the fixed-width FIFO multiplier.
- An input FIFO buffers parity-protected operands. A controller pops them in pairs and produces an unsigned product, registered, with a generated parity bit and a per-result parity-error flag.
- Adds configurable width/depth, odd/even parity mode, output backpressure, synchronous flush and an occupancy output.
- Sits between the operand source bus and the result consumer in the arithmetic datapath.

---
 rtl/fifomult_if.sv | 29 ++
 rtl/fifomult_param.sv | 143 ++++++++++++++
 tb/tb_fifomult_param.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifomult_if.sv
// Operand/result bus of the parity-checked FIFO multiplier: operand write side,
// result handshake side and the occupancy readback.
interface fifomult_if #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  din_valid;
  logic [DATA_W-1:0]     din;
  logic                  din_parity;
  logic                  din_ready;
  logic                  dout_valid;
  logic [2*DATA_W-1:0]   dout;
  logic                  dout_parity;
  logic                  dout_err;
  logic                  dout_ready;
  logic [CW-1:0]         fifo_count;

  modport master (
    output din_valid, din, din_parity, dout_ready,
    input  din_ready, dout_valid, dout, dout_parity, dout_err, fifo_count
  );

  modport slave (
    input  din_valid, din, din_parity, dout_ready,
    output din_ready, dout_valid, dout, dout_parity, dout_err, fifo_count
  );
endinterface

// File: rtl/fifomult_param.sv
// Parity-checked operand FIFO feeding a pairwise unsigned multiplier; results are
// held under backpressure with a regenerated parity bit and an operand-error flag.
module fifomult_param #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  fifomult_if.slave bus
);
  localparam int   AW  = $clog2(FIFO_DEPTH);
  localparam int   CW  = AW + 1;
  localparam int   PW  = 2 * DATA_W;
  localparam logic ODD = (PARITY_ODD != 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_POP_B  = 2'd1;
  localparam logic [1:0] S_MULT   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  function automatic logic par_op(input logic [DATA_W-1:0] d);
    return (^d) ^ ODD;
  endfunction

  function automatic logic par_res(input logic [PW-1:0] d);
    return (^d) ^ ODD;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W:0]   a_q, a_d, b_q, b_d;
  logic [PW-1:0]     dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              dout_parity_q, dout_parity_d;
  logic              dout_err_q, dout_err_d;

  logic              full, push, pop, op_err;
  logic [DATA_W:0]   head, wr_word;
  logic [PW-1:0]     prod;

  // Each FIFO entry carries its own parity-error bit so the check travels with the word.
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign push    = bus.din_valid && !full;
  assign head    = mem_q[rd_ptr_q];
  assign wr_word = {bus.din_parity != par_op(bus.din), bus.din};
  assign prod    = PW'(a_q[DATA_W-1:0]) * PW'(b_q[DATA_W-1:0]);
  assign op_err  = a_q[DATA_W] | b_q[DATA_W];

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    dout_parity_d = dout_parity_q;
    dout_err_d    = dout_err_q;
    pop           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q >= CW'(2)) begin
          a_d     = head;
          pop     = 1'b1;
          state_d = S_POP_B;
        end
      end
      S_POP_B: begin
        b_d     = head;
        pop     = 1'b1;
        state_d = S_MULT;
      end
      S_MULT: begin
        dout_d        = op_err ? '0 : prod;
        dout_err_d    = op_err;
        dout_parity_d = par_res(dout_d);
        dout_valid_d  = 1'b1;
        state_d       = S_RESULT;
      end
      S_RESULT: begin
        if (dout_valid_q && bus.dout_ready) begin
          dout_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      dout_parity_q <= 1'b0;
      dout_err_q    <= 1'b0;
    end else if (flush) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      dout_parity_q <= 1'b0;
      dout_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      dout_parity_q <= dout_parity_d;
      dout_err_q    <= dout_err_d;
    end
  end

  // Storage and operand latches need no reset: the FSM never consumes them unless filled.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    if (push && !flush) mem_q[wr_ptr_q] <= wr_word;
  end

  assign bus.din_ready   = !full;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.dout        = dout_q;
  assign bus.dout_parity = dout_parity_q;
  assign bus.dout_err    = dout_err_q;
  assign bus.fifo_count  = count_q;
endmodule

// File: tb/tb_fifomult_param.sv
// Bench for fifomult_param: an even-parity instance checked every cycle against a
// timing-level reference model, plus an odd-parity instance with directed checks.
module tb_fifomult_param;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush0 = 1'b0;
  logic flush1 = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  fifomult_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus0 ();
  fifomult_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus1 ();

  fifomult_param #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0), .bus(bus0));
  fifomult_param #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(bus1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue; a result is started on the first
  // edge the multiplier is free with two words waiting, pops A then B on
  // consecutive edges and shows the product from the edge after that.
  logic [DW:0]   m_fifo[$];
  int            m_cyc = 0;
  int            m_start = 0;
  bit            m_busy = 1'b0;
  bit            m_valid = 1'b0;
  bit            m_wr;
  logic [DW:0]   m_a, m_b;
  logic [31:0]   m_dout = '0, p_dout = '0;
  logic          m_par = 1'b0, m_err = 1'b0, p_par = 1'b0, p_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush0) begin
      m_fifo.delete();
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_dout  = '0;
      m_par   = 1'b0;
      m_err   = 1'b0;
    end else begin
      m_cyc++;
      m_wr = bus0.din_valid && (m_fifo.size() < DEPTH);
      if (m_busy) begin
        if (m_cyc == m_start + 1) void'(m_fifo.pop_front());
        else if (m_cyc == m_start + 2) begin
          m_valid = 1'b1;
          m_dout  = p_dout;
          m_par   = p_par;
          m_err   = p_err;
        end else if (m_valid && bus0.dout_ready) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
        end
      end else if (m_fifo.size() >= 2) begin
        m_busy  = 1'b1;
        m_start = m_cyc;
        m_a     = m_fifo[0];
        m_b     = m_fifo[1];
        p_err   = m_a[DW] | m_b[DW];
        p_dout  = p_err ? 32'd0 : 32'(m_a[DW-1:0]) * 32'(m_b[DW-1:0]);
        p_par   = ^p_dout;
        void'(m_fifo.pop_front());
      end
      if (m_wr) m_fifo.push_back({bus0.din_parity != (^bus0.din), bus0.din});
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_valid", bus0.dout_valid, m_valid);
      chk("m_count", bus0.fifo_count, m_fifo.size());
      chk("m_din_ready", bus0.din_ready, m_fifo.size() < DEPTH);
      chk("m_dout", bus0.dout, m_dout);
      chk("m_parity", bus0.dout_parity, m_par);
      chk("m_err", bus0.dout_err, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [DW-1:0] d, input logic p);
    bus0.din_valid = 1'b1; bus0.din = d; bus0.din_parity = p;
    step();
    bus0.din_valid = 1'b0;
  endtask

  task automatic wr1(input logic [DW-1:0] d, input logic p);
    bus1.din_valid = 1'b1; bus1.din = d; bus1.din_parity = p;
    step();
    bus1.din_valid = 1'b0;
  endtask

  task automatic wait_v0(input string nm);
    int n = 0;
    while (!bus0.dout_valid && n < 20) begin step(); n++; end
    chk({nm, "_valid"}, bus0.dout_valid, 1);
  endtask

  task automatic wait_v1(input string nm);
    int n = 0;
    while (!bus1.dout_valid && n < 20) begin step(); n++; end
    chk({nm, "_valid"}, bus1.dout_valid, 1);
  endtask

  logic [31:0] bp_exp [5] = '{32'd2, 32'd12, 32'd30, 32'd56, 32'd90};

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] v;
    int acc, got, seen;
    bit take;
    bus0.din_valid = 1'b0; bus0.din = '0; bus0.din_parity = 1'b0; bus0.dout_ready = 1'b1;
    bus1.din_valid = 1'b0; bus1.din = '0; bus1.din_parity = 1'b0; bus1.dout_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_valid", bus0.dout_valid, 0);
    chk("rst_dout", bus0.dout, 0);
    chk("rst_count", bus0.fifo_count, 0);
    chk("rst_ready", bus0.din_ready, 1);
    mon_en = 1'b1;

    // Randomized traffic with a mid-stream asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      bus0.din_valid  = ($urandom_range(0, 1) == 1);
      bus0.din        = d;
      bus0.din_parity = ($urandom_range(0, 4) == 0) ? ~(^d) : (^d);
      bus0.dout_ready = ($urandom_range(0, 9) < 7);
      flush0          = ($urandom_range(0, 99) == 0);
      step();
      if (i == 300) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus0.dout_valid, 0);
        chk("async_rst_count", bus0.fifo_count, 0);
        chk("async_rst_ready", bus0.din_ready, 1);
        step();
        rst_n = 1'b1;
      end
    end
    bus0.din_valid = 1'b0; bus0.dout_ready = 1'b1; flush0 = 1'b0;
    repeat (40) step();
    flush0 = 1'b1; step(); flush0 = 1'b0;
    chk("drain_count", bus0.fifo_count, 0);

    // Basic pair with exact latency.
    wr0(16'd3, 1'b0);
    wr0(16'd5, 1'b0);
    chk("lat_w0", bus0.dout_valid, 0);
    step(); chk("lat_w1", bus0.dout_valid, 0);
    step(); chk("lat_w2", bus0.dout_valid, 0);
    step(); chk("lat_w3", bus0.dout_valid, 1);
    chk("basic_dout", bus0.dout, 32'h0000000F);
    chk("basic_par", bus0.dout_parity, 0);
    chk("basic_err", bus0.dout_err, 0);
    chk("basic_model", m_dout, 32'd15);
    repeat (3) step();

    wr0(16'hFFFF, 1'b0);
    wr0(16'hFFFF, 1'b0);
    wait_v0("max");
    chk("max_dout", bus0.dout, 32'hFFFE0001);
    chk("max_par", bus0.dout_parity, 0);
    chk("max_err", bus0.dout_err, 0);
    repeat (3) step();

    wr0(16'd7, 1'b0);
    wr0(16'd2, 1'b0);
    wait_v0("perr");
    chk("perr_dout", bus0.dout, 0);
    chk("perr_err", bus0.dout_err, 1);
    chk("perr_par", bus0.dout_parity, 0);
    step();
    wr0(16'd4, 1'b1);
    wr0(16'd6, 1'b0);
    wait_v0("good");
    chk("good_dout", bus0.dout, 32'd24);
    chk("good_err", bus0.dout_err, 0);
    chk("good_model", m_dout, 32'd24);
    repeat (3) step();

    // Backpressure until the FIFO fills.
    bus0.dout_ready = 1'b0;
    v = 16'd1; acc = 0;
    for (int i = 0; i < 24; i++) begin
      bus0.din_valid = 1'b1; bus0.din = v; bus0.din_parity = ^v;
      take = bus0.din_ready;
      step();
      if (take) begin acc++; v = v + 16'd1; end
    end
    bus0.din_valid = 1'b0;
    chk("bp_accepted", acc, 10);
    chk("bp_ready", bus0.din_ready, 0);
    chk("bp_count", bus0.fifo_count, 8);
    bus0.dout_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 60 && got < 5; k++) begin
      if (bus0.dout_valid) begin
        chk("bp_dout", bus0.dout, bp_exp[got]);
        chk("bp_model", m_dout, bp_exp[got]);
        got++;
      end
      step();
    end
    chk("bp_results", got, 5);
    repeat (3) step();
    chk("bp_count_end", bus0.fifo_count, 0);

    // Odd-parity instance.
    wr1(16'd3, 1'b1);
    wr1(16'd5, 1'b1);
    wait_v1("odd");
    chk("odd_dout", bus1.dout, 32'd15);
    chk("odd_par", bus1.dout_parity, 1);
    chk("odd_err", bus1.dout_err, 0);
    repeat (3) step();
    wr1(16'd9, 1'b1);
    chk("odd_one", bus1.fifo_count, 1);
    flush1 = 1'b1;
    bus1.din_valid = 1'b1; bus1.din = 16'd2; bus1.din_parity = 1'b0;
    step();
    flush1 = 1'b0; bus1.din_valid = 1'b0;
    chk("flush_count", bus1.fifo_count, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus1.dout_valid) seen++;
      step();
    end
    chk("flush_no_result", seen, 0);
    chk("flush_count_end", bus1.fifo_count, 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
